// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Frame lasts NBITS*CLKS_PER_BIT cycles from accept; Tx_Ready only in IDLE, so busy frames backpressure the source.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Tx_Valid,
  output logic                 Tx_Ready,
  output logic                 Serial_Out,
  output logic                 UBusy,
  output logic                 Tx_Done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY_MODE == 2);
  localparam logic          HAS_PAR   = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [CW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   ser_d, busy_d, done_d;
  logic                   bit_end;

  assign Tx_Ready = (state_q == S_IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      Serial_Out <= 1'b1;
      UBusy      <= 1'b0;
      Tx_Done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      Serial_Out <= ser_d;
      UBusy      <= busy_d;
      Tx_Done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    ser_d   = Serial_Out;
    busy_d  = UBusy;
    done_d  = 1'b0;
    bit_end = (baud_q == BAUD_LAST);

    // Baud counter free-runs inside a frame; every wrap marks the end of one serial bit.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (Tx_Valid) begin
          state_d = S_START;
          shreg_d = Tx_Data;
          par_d   = (^Tx_Data) ^ ODD_PAR;
          ser_d   = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          ser_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = S_PARITY;
              ser_d   = par_q;
            end else begin
              state_d = S_STOP;
              ser_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            ser_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          ser_d   = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            ser_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8E1, 8O1, 8N1, 7N2) at 4 clocks per bit.
module tb_uart_tx_param;
  localparam int CPB = 4;

  typedef struct {
    int          c;
    logic [7:0]  d;
    logic [11:0] bits;
    int          nbits;
  } vec_t;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdat [4];
  logic       tvld [4];
  logic       trdy [4];
  logic       sout [4];
  logic       ubusy [4];
  logic       tdone [4];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .Clk(clk), .Rst(rst_n), .Tx_Data(tdat[0]), .Tx_Valid(tvld[0]), .Tx_Ready(trdy[0]),
    .Serial_Out(sout[0]), .UBusy(ubusy[0]), .Tx_Done(tdone[0]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .Clk(clk), .Rst(rst_n), .Tx_Data(tdat[1]), .Tx_Valid(tvld[1]), .Tx_Ready(trdy[1]),
    .Serial_Out(sout[1]), .UBusy(ubusy[1]), .Tx_Done(tdone[1]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .Clk(clk), .Rst(rst_n), .Tx_Data(tdat[2]), .Tx_Valid(tvld[2]), .Tx_Ready(trdy[2]),
    .Serial_Out(sout[2]), .UBusy(ubusy[2]), .Tx_Done(tdone[2]));
  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .Clk(clk), .Rst(rst_n), .Tx_Data(tdat[3][6:0]), .Tx_Valid(tvld[3]), .Tx_Ready(trdy[3]),
    .Serial_Out(sout[3]), .UBusy(ubusy[3]), .Tx_Done(tdone[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Present a word at a falling edge, hold it through the accept edge, then scramble Tx_Data.
  task automatic send(input int c, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tdat[c] = d;
    tvld[c] = 1'b1;
    while (!trdy[c] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("send_ready");
    @(posedge clk);
    @(negedge clk);
    tvld[c] = 1'b0;
    tdat[c] = ~d;
  endtask

  // Pops the next expected frame and follows the line from its start bit to one cycle past Tx_Done.
  task automatic check_frame(input int c, output int start_cyc);
    exp_t e;
    int   n = 0;
    int   nb;
    int   bad = 0;
    start_cyc = -1;
    if (sb.size() == 0) begin
      timeout("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    while (sout[c] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      timeout($sformatf("c%0d_start", c));
      return;
    end
    start_cyc = cyc;
    nb = e.nbits * CPB;
    for (int i = 0; i <= nb; i++) begin
      if (i % CPB == CPB / 2)
        chk($sformatf("c%0d_bit%0d", c, i / CPB), {31'd0, sout[c]}, {31'd0, e.bits[i / CPB]});
      if (i < nb && !(ubusy[c] === 1'b1 && tdone[c] === 1'b0 && trdy[c] === 1'b0)) bad++;
      if (i == nb)
        chk($sformatf("c%0d_done_at_%0d", c, nb),
            {28'd0, tdone[c], ubusy[c], sout[c], trdy[c]}, 32'b1011);
      @(negedge clk);
    end
    chk($sformatf("c%0d_busy_window", c), bad, 0);
    chk($sformatf("c%0d_done_one_cycle", c), {31'd0, tdone[c]}, 32'd0);
  endtask

  initial begin
    vec_t tbl [9];
    int   s0, s1, n, bad;

    for (int c = 0; c < 4; c++) begin
      tvld[c] = 1'b0;
      tdat[c] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++)
      chk($sformatf("c%0d_reset", c), {28'd0, sout[c], ubusy[c], tdone[c], trdy[c]}, 32'b1001);
    rst_n = 1'b1;

    // Frame bits listed stop..start, so bit k of the vector is the k-th symbol on the line.
    tbl[0] = '{0, 8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    tbl[1] = '{0, 8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11};
    tbl[2] = '{1, 8'h01, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11};
    tbl[3] = '{2, 8'h01, {2'b00, 1'b1, 8'h01, 1'b0}, 10};
    tbl[4] = '{3, 8'h7F, {2'b00, 2'b11, 7'h7F, 1'b0}, 10};
    tbl[5] = '{1, 8'hA5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
    tbl[6] = '{2, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10};
    tbl[7] = '{3, 8'h2A, {2'b00, 2'b11, 7'h2A, 1'b0}, 10};
    tbl[8] = '{0, 8'h80, {1'b0, 1'b1, 1'b1, 8'h80, 1'b0}, 11};

    for (int i = 0; i < 9; i++) begin
      sb.push_back('{tbl[i].bits, tbl[i].nbits});
      send(tbl[i].c, tbl[i].d);
      check_frame(tbl[i].c, s0);
      repeat (2) @(negedge clk);
    end

    // Back-to-back: Tx_Valid held high across two words.
    sb.push_back('{{1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11});
    sb.push_back('{{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0}, 11});
    @(negedge clk);
    tdat[0] = 8'h55;
    tvld[0] = 1'b1;
    fork
      begin
        check_frame(0, s0);
        check_frame(0, s1);
      end
      begin
        int k = 0;
        @(posedge clk);
        @(negedge clk);
        tdat[0] = 8'hAA;
        while (!trdy[0] && k < 200) begin
          @(negedge clk);
          k++;
        end
        if (k >= 200) timeout("b2b_ready");
        @(posedge clk);
        @(negedge clk);
        tvld[0] = 1'b0;
        tdat[0] = 8'h00;
      end
    join
    chk("b2b_start_spacing", s1 - s0, 45);

    // Busy ignore: a 0xFF offered mid-frame must be dropped.
    repeat (2) @(negedge clk);
    sb.push_back('{{1'b0, 1'b1, 1'b0, 8'h0F, 1'b0}, 11});
    send(0, 8'h0F);
    fork
      check_frame(0, s0);
      begin
        repeat (14) @(negedge clk);
        tdat[0] = 8'hFF;
        tvld[0] = 1'b1;
        repeat (3) @(negedge clk);
        tvld[0] = 1'b0;
      end
    join
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (sout[0] !== 1'b1 || ubusy[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("ff_never_sent", bad, 0);

    // Reset during data bit 3, then a clean frame.
    send(0, 8'h3C);
    repeat (18) @(negedge clk);
    chk("pre_reset_bit3", {31'd0, sout[0]}, 32'd1);
    chk("pre_reset_busy", {31'd0, ubusy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {28'd0, sout[0], ubusy[0], tdone[0], trdy[0]}, 32'b1001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, trdy[0]}, 32'd1);
    n = 0;
    sb.push_back('{{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11});
    send(0, 8'h3C);
    check_frame(0, s0);
    n = sb.size();
    chk("scoreboard_drained", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
